// File: rtl/layer_nn_pkg.sv
// ============================================================================
// Module  : layer_nn_pkg
// Purpose : Shared constants and state type for the layer-2 classifier blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_nn_pkg;

  localparam int L2_NUM_CLASS  = 10;
  localparam int L2_DATA_WIDTH = 29;
  localparam int L2_IDX_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
// ============================================================================
// Module  : argmax_cmp
// Purpose : Signed compare-and-select; a candidate replaces the best only when
//           strictly greater, so ties keep the earlier (lower) index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module argmax_cmp #(
  parameter int DATA_WIDTH = 29,
  parameter int IDX_WIDTH  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] cand_val,
  input  logic        [IDX_WIDTH-1:0]  cand_idx,
  input  logic signed [DATA_WIDTH-1:0] best_val,
  input  logic        [IDX_WIDTH-1:0]  best_idx,
  output logic signed [DATA_WIDTH-1:0] new_val,
  output logic        [IDX_WIDTH-1:0]  new_idx
);

  logic w_take;

  assign w_take  = (cand_val > best_val);
  assign new_val = w_take ? cand_val : best_val;
  assign new_idx = w_take ? cand_idx : best_idx;

endmodule

`default_nettype wire

// File: rtl/layer_argmax_10x29.sv
// ============================================================================
// Module  : layer_argmax_10x29
// Purpose : Sequential argmax over NUM_CLASS signed logits, one compare per
//           cycle, result under valid/ready. Optional max_score output is
//           enabled by defining LAYER_ARGMAX_SCORE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_argmax_10x29
  import layer_nn_pkg::*;
#(
  parameter int NUM_CLASS  = L2_NUM_CLASS,
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int IDX_WIDTH  = L2_IDX_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH*NUM_CLASS-1:0] layer_in,
  output logic                            in_ready,
  output logic [IDX_WIDTH-1:0]            class_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            drop_err
`ifdef LAYER_ARGMAX_SCORE_EN
  ,
  output logic signed [DATA_WIDTH-1:0]    max_score
`endif
);

  argmax_state_t r_state, w_state_nxt;

  logic signed [DATA_WIDTH-1:0] r_buf [NUM_CLASS];
  logic signed [DATA_WIDTH-1:0] r_best_val;
  logic        [IDX_WIDTH-1:0]  r_best_idx;
  logic        [IDX_WIDTH-1:0]  r_cnt;
  logic signed [DATA_WIDTH-1:0] w_new_val;
  logic        [IDX_WIDTH-1:0]  w_new_idx;
  logic                         w_last;

  assign w_last    = (r_cnt == IDX_WIDTH'(NUM_CLASS - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .cand_val (r_buf[r_cnt]),
    .cand_idx (r_cnt),
    .best_val (r_best_val),
    .best_idx (r_best_idx),
    .new_val  (w_new_val),
    .new_idx  (w_new_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SCAN;
      SCAN:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Datapath; words arriving outside IDLE are discarded and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASS; k++) r_buf[k] <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      class_out  <= '0;
      drop_err   <= 1'b0;
`ifdef LAYER_ARGMAX_SCORE_EN
      max_score  <= '0;
`endif
    end else begin
      if (in_valid && (r_state != IDLE)) drop_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_CLASS; k++)
              r_buf[k] <= layer_in[k*DATA_WIDTH +: DATA_WIDTH];
            r_best_val <= layer_in[DATA_WIDTH-1:0];
            r_best_idx <= '0;
            r_cnt      <= IDX_WIDTH'(1);
          end
        end
        SCAN: begin
          r_best_val <= w_new_val;
          r_best_idx <= w_new_idx;
          r_cnt      <= r_cnt + 1'b1;
          if (w_last) begin
            class_out <= w_new_idx;
`ifdef LAYER_ARGMAX_SCORE_EN
            max_score <= w_new_val;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/layer_argmax_10x29.md
Name: layer_argmax_10x29

Overview:
- Classifier output stage. Sits directly downstream of the 144x16x10 ternary layer-2 block.
- Accepts its ten 29-bit signed logits, with the handshake driven by that block's `ready` output.
- Performs a sequential argmax, one comparison per cycle, and presents the winning class index under a valid/ready output handshake.
- Reports input words dropped while busy.

Parameters:
- NUM_CLASS, 10, number of logits per input word.
- DATA_WIDTH, 29, width of each signed two's-complement logit.
- IDX_WIDTH, 4, width of the class index; must satisfy 2**IDX_WIDTH >= NUM_CLASS.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  logits valid; connected to the upstream `ready`.
- layer_in  input  DATA_WIDTH*NUM_CLASS  packed logits; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  1  high only in IDLE.
- class_out  output  IDX_WIDTH  winning class index.
- out_valid  output  1  class_out valid.
- out_ready  input  1  downstream accepts the result.
- drop_err  output  1  sticky flag: an input word arrived while busy.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, in_ready=1, out_valid=0, class_out=0, drop_err=0; buffer, best and count cleared.
- Release of reset is synchronous to clk.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On edge with in_valid=1, capture all NUM_CLASS logits into an internal buffer.
  - best_val=logit0, best_idx=0, cnt=1; go to SCAN.
  - in_ready goes 0 after this edge.
- SCAN:
  - Each edge compares buf[cnt] against best_val, signed.
  - Strictly greater replaces best_val/best_idx; ties keep the lower index.
  - cnt increments.
  - On the edge processing cnt==NUM_CLASS-1: go to DONE, load class_out=best result, set out_valid=1.
- Latency: out_valid rises NUM_CLASS-1 edges (9 by default) after the capturing edge.
- DONE:
  - class_out and out_valid are held stable until out_ready=1.
  - On an edge with out_valid & out_ready: out_valid=0, state=IDLE, in_ready=1 after that edge.
  - A new word is accepted on the first edge in IDLE; there is no same-edge bypass.
- Input dropping:
  - Any in_valid=1 edge while state != IDLE discards the word and sets drop_err=1.
  - drop_err clears only on reset.
  - The upstream block has no backpressure, so dropping is the defined behaviour.
- Arithmetic:
  - All comparisons are full DATA_WIDTH signed; no truncation.
  - Most-negative value (-2^28) handled correctly.
- Reset mid-SCAN or mid-DONE: immediate return to reset values; the partial result is discarded.
- class_out changes only on the edge entering DONE.

Optional Feature:
- Macro LAYER_ARGMAX_SCORE_EN.
- When defined:
  - Adds output port max_score (DATA_WIDTH, signed), holding the winning logit value.
  - max_score is loaded and held exactly like class_out, with reset value 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package layer_nn_pkg:
  - Constants L2_NUM_CLASS=10, L2_DATA_WIDTH=29, L2_IDX_WIDTH=4.
  - State typedef argmax_state_t {IDLE, SCAN, DONE}.
- One natural sub-module, argmax_cmp:
  - Combinational signed compare-and-select.
  - Inputs: candidate value/index, current best value/index. Outputs: new best value/index.
  - Strict-greater rule, ties kept.

Test Plan:
- Logits 0..9 = {5,-3,100,7,100,-200,0,99,1,2}, in_valid pulse, out_ready=1 -> out_valid rises 9 edges after capture; class_out=2 (tie with class 4 resolved to the lower index); max_score=100 when enabled.
- All logits = -268435456 (most negative) -> class_out=0. Then class 9 = -268435455, others most negative -> class_out=9.
- Result with out_ready=0 for 20 cycles, then 1 -> class_out/out_valid stable throughout; in_ready returns to 1 the edge after the handshake.
- Second in_valid pulse 3 cycles after the first capture -> second word ignored; drop_err=1 and stays 1; first result unaffected.
- Assert rst low during SCAN cycle 5 -> out_valid=0, in_ready=1 immediately (asynchronous). A new word after release gives the correct argmax.
- Back-to-back words, each accepted the first IDLE edge after the previous handshake; random signed logits over 1000 words -> class_out matches the reference-model argmax with lowest-index tie-break; drop_err=0.
